sobel_conv3x3: RTL and testbench
================================

Name: sobel_conv3x3

Overview:
- Streaming 3x3 Sobel convolution engine for the camera edge-detection path; successor to the single-tap filter grid cell.
- Accepts a raster pixel stream, builds the 3x3 window internally from two line buffers plus a window shift register, and emits one signed gradient per interior pixel.
- Parametrised in pixel width and frame size; four output modes, latched per frame.
- Sits between the grayscale converter and the display/VGA write path.

Parameters:
DATA_W, 12, input pixel width (unsigned)
IMG_W, 640, pixels per row (>=3)
IMG_H, 480, rows per frame (>=3)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  pixel beat qualifier
in_pixel  input  DATA_W  unsigned pixel, raster order
in_sof  input  1  start of frame, valid only with in_valid; marks pixel (0,0)
mode  input  2  0=Gx, 1=Gy, 2=|Gx|+|Gy|, 3=centre-pixel passthrough
out_valid  output  1  result beat
out_data  output  DATA_W+4  signed result, 2's complement
out_eof  output  1  high with the last result of a frame

Behaviour:
- Reset (rst high at clk edge): out_valid=0, out_data=0, out_eof=0, col/row counters=0, latched mode=0, all pipeline valid bits=0. Line buffer and window contents are not reset; they are masked by the counters. Reset mid-frame drops all in-flight results. The next output appears only after a full new window is received.
- Position counters advance only on in_valid beats. in_valid && in_sof forces the beat to position (0,0) regardless of the counters. col wraps at IMG_W-1 -> 0 with row+1. row wraps at IMG_H-1 -> 0 after the last column. A frame without a following sof continues as a new frame from (0,0).
- mode is sampled on the in_valid && in_sof beat only. Changes mid-frame are ignored until the next sof.
- Window: the in_valid beat at (r,c) with r>=2 and c>=2 completes the window centred at (r-1,c-1). The window shifts every in_valid beat, including row-edge beats, and never shifts on idle cycles.
- Kernels, window rows listed top row first:
  - Gx = [-1 0 1; -2 0 2; -1 0 1].
  - Gy = [-1 -2 -1; 0 0 0; 1 2 1].
- Arithmetic: operands zero-extended to DATA_W+4 signed. Products by 2 are implemented as shifts. |Gx|,|Gy| <= 4*(2^DATA_W-1), so the mode-2 sum fits in DATA_W+4 bits with no overflow possible. Mode 3 outputs the centre pixel zero-extended.
- Pipeline: stage 1 computes partial row/column sums; stage 2 computes final sums, abs and mode mux, and registers the output. out_valid rises exactly 2 clk cycles after the completing in_valid beat. No backpressure; the block accepts one beat per cycle.
- Output count per frame = (IMG_W-2)*(IMG_H-2). No outputs for border centres. out_eof is high together with the result for centre (IMG_H-2, IMG_W-2).
- When out_valid=0, out_data holds its last value.
- Gaps in in_valid do not change the results or their order, only their timing.
- A simultaneous sof and a window-completing counter position: sof wins, the beat is (0,0), and no output is produced for it.

Optional Feature:
SOBEL_CLAMP_EN
- Defined: the stage-2 result is clamped to the range 0..2^DATA_W-1 and zero-extended onto out_data (negative -> 0, >2^DATA_W-1 -> 2^DATA_W-1). Latency is unchanged.
- Undefined: the full signed DATA_W+4 result is output unmodified.

Test Plan:
All scenarios use IMG_W=8, IMG_H=6, DATA_W=12, one sof per frame.
- Constant frame, all pixels 100, mode 0 -> exactly 24 out_valid pulses, all out_data=0, out_eof on the 24th only.
- Horizontal ramp, pixel=10*col, mode 0 -> 24 results of +80. Same frame with mode 1 -> 24 results of 0.
- Vertical ramp, pixel=10*row, mode 1 -> 24 results of +80. Mode 2 -> 80. Mode 3 -> centre values 10,10,...,40 row by row.
- Impulse 4095 at (2,3), else 0, mode 2 -> centre (2,2)=8190; with SOBEL_CLAMP_EN -> 4095. Mode 0, centre (2,4) -> -8190 without the macro, 0 with it.
- Repeat the horizontal-ramp frame with in_valid low every other cycle, and toggle mode to 1 mid-frame -> identical 24 values of +80; each out_valid exactly 2 cycles after its completing beat.
- Assert rst for 1 cycle at beat (3,5), then send a new sof frame -> no out_valid until beat (2,2) of the new frame plus 2 cycles, then 24 correct results.

Source files
------------

// File: rtl/sobel_conv3x3.sv
// Streaming 3x3 Sobel engine: two line buffers plus a 3x3 window feed a 2-stage gradient pipeline.
// Optional macro SOBEL_CLAMP_EN clamps the result to 0..2^DATA_W-1.
module sobel_conv3x3 #(
  parameter int DATA_W = 12,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_pixel,
  input  logic                     in_sof,
  input  logic [1:0]               mode,
  output logic                     out_valid,
  output logic signed [DATA_W+3:0] out_data,
  output logic                     out_eof
);
  localparam int OW = DATA_W + 4;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic signed [OW-1:0] PIX_MAX = OW'((1 << DATA_W) - 1);

  function automatic logic signed [OW-1:0] ext(input logic [DATA_W-1:0] x);
    return signed'({4'b0000, x});
  endfunction

  logic [CW-1:0] col_q, col_d, col_pos;
  logic [RW-1:0] row_q, row_d, row_pos;
  logic [1:0]    mode_q, mode_d, mode0_q, mode1_q;
  logic          sof_beat;
  logic          vld0_q, vld0_d, eof0_q, eof0_d;
  logic          vld1_q, eof1_q;
  logic          out_valid_q, out_eof_q;
  logic signed [OW-1:0] out_data_q, out_data_d;

  logic [DATA_W-1:0] lb_mid [IMG_W];
  logic [DATA_W-1:0] lb_top [IMG_W];
  logic [2:0][2:0][DATA_W-1:0] win_q, win_d;

  logic signed [OW-1:0] sum_l_q, sum_l_d, sum_r_q, sum_r_d;
  logic signed [OW-1:0] sum_t_q, sum_t_d, sum_b_q, sum_b_d;
  logic signed [OW-1:0] ctr_q, ctr_d;
  logic signed [OW-1:0] gx, gy, abs_x, abs_y, res;

  // A sof beat is pixel (0,0) no matter where the counters are.
  always_comb begin
    sof_beat = in_valid && in_sof;
    col_pos  = sof_beat ? '0 : col_q;
    row_pos  = sof_beat ? '0 : row_q;
    col_d    = col_q;
    row_d    = row_q;
    mode_d   = sof_beat ? mode : mode_q;
    if (in_valid) begin
      if (col_pos == COL_LAST) begin
        col_d = '0;
        row_d = (row_pos == ROW_LAST) ? '0 : row_pos + 1'b1;
      end else begin
        col_d = col_pos + 1'b1;
        row_d = row_pos;
      end
    end
    vld0_d = in_valid && (row_pos >= ROW_TWO) && (col_pos >= COL_TWO);
    eof0_d = in_valid && (row_pos == ROW_LAST) && (col_pos == COL_LAST);
  end

  // Window row 0 is the oldest line, column 2 the newest pixel.
  always_comb begin
    win_d = win_q;
    if (in_valid) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb_top[col_pos];
      win_d[1][2] = lb_mid[col_pos];
      win_d[2][2] = in_pixel;
    end
  end

  always_comb begin
    sum_l_d = ext(win_q[0][0]) + (ext(win_q[1][0]) <<< 1) + ext(win_q[2][0]);
    sum_r_d = ext(win_q[0][2]) + (ext(win_q[1][2]) <<< 1) + ext(win_q[2][2]);
    sum_t_d = ext(win_q[0][0]) + (ext(win_q[0][1]) <<< 1) + ext(win_q[0][2]);
    sum_b_d = ext(win_q[2][0]) + (ext(win_q[2][1]) <<< 1) + ext(win_q[2][2]);
    ctr_d   = ext(win_q[1][1]);
  end

  always_comb begin
    gx    = sum_r_q - sum_l_q;
    gy    = sum_b_q - sum_t_q;
    abs_x = gx[OW-1] ? -gx : gx;
    abs_y = gy[OW-1] ? -gy : gy;
    unique case (mode1_q)
      2'd0:    res = gx;
      2'd1:    res = gy;
      2'd2:    res = abs_x + abs_y;
      default: res = ctr_q;
    endcase
`ifdef SOBEL_CLAMP_EN
    if (res[OW-1]) begin
      res = '0;
    end else if (res > PIX_MAX) begin
      res = PIX_MAX;
    end
`endif
    out_data_d = vld1_q ? res : out_data_q;
  end

  // Line buffers and window data are never reset; the counters mask stale content.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb_top[col_pos] <= lb_mid[col_pos];
      lb_mid[col_pos] <= in_pixel;
    end
    win_q   <= win_d;
    sum_l_q <= sum_l_d;
    sum_r_q <= sum_r_d;
    sum_t_q <= sum_t_d;
    sum_b_q <= sum_b_d;
    ctr_q   <= ctr_d;
    mode0_q <= mode_d;
    mode1_q <= mode0_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      mode_q      <= '0;
      vld0_q      <= 1'b0;
      eof0_q      <= 1'b0;
      vld1_q      <= 1'b0;
      eof1_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_eof_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      mode_q      <= mode_d;
      vld0_q      <= vld0_d;
      eof0_q      <= eof0_d;
      vld1_q      <= vld0_q;
      eof1_q      <= eof0_q;
      out_valid_q <= vld1_q;
      out_eof_q   <= vld1_q && eof1_q;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_eof   = out_eof_q;
  assign out_data  = out_data_q;
endmodule

// File: tb/tb_sobel_conv3x3.sv
// Directed, table-driven bench for sobel_conv3x3 on an 8x6 frame with 12-bit pixels.
// Expected values are hand-derived; SOBEL_CLAMP_EN selects the clamped expectations.
`timescale 1ns/1ps
module tb_sobel_conv3x3;
  localparam int DW   = 12;
  localparam int W    = 8;
  localparam int H    = 6;
  localparam int NOUT = (W - 2) * (H - 2);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic [DW-1:0]        in_pixel;
  logic                 in_sof;
  logic [1:0]           mode;
  logic                 out_valid;
  logic signed [DW+3:0] out_data;
  logic                 out_eof;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int q_data[$];
  int q_eof[$];
  int q_cyc[$];
  int beat_cyc[$];

  typedef struct {
    string    name;
    int       pattern;
    logic [1:0] md;
    bit       gapped;
    bit       toggle;
    int       kind;
    int       value;
  } vec_t;

  vec_t vecs[7];

  sobel_conv3x3 #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_pixel (in_pixel),
    .in_sof   (in_sof),
    .mode     (mode),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_eof  (out_eof)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every result with the cycle it appeared in.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      q_data.push_back(int'(out_data));
      q_eof.push_back(int'(out_eof));
      q_cyc.push_back(cyc);
    end
  end

  function automatic logic [DW-1:0] pix(input int pat, input int r, input int c);
    case (pat)
      0:       return DW'(100);
      1:       return DW'(10 * c);
      2:       return DW'(10 * r);
      default: return (r == 2 && c == 3) ? DW'(4095) : DW'(0);
    endcase
  endfunction

  task automatic checkOutput(input string name, input int got, input int exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] p, input bit sof, input logic [1:0] md,
                               input bit valid);
    @(negedge clk);
    in_valid = valid;
    in_pixel = p;
    in_sof   = sof;
    mode     = md;
  endtask

  task automatic clearQueues();
    q_data.delete();
    q_eof.delete();
    q_cyc.delete();
    beat_cyc.delete();
  endtask

  task automatic sendFrame(input int pat, input logic [1:0] md, input bit gapped, input bit toggle);
    logic [1:0] m;
    clearQueues();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        m = (toggle && r >= 3) ? 2'd1 : md;
        applyStimulus(pix(pat, r, c), (r == 0 && c == 0), m, 1'b1);
        if (r >= 2 && c >= 2) beat_cyc.push_back(cyc + 1);
        if (gapped) applyStimulus('0, 1'b0, m, 1'b0);
      end
    end
    for (int i = 0; i < 6; i++) applyStimulus('0, 1'b0, md, 1'b0);
  endtask

  task automatic checkFrame(input string name, input int kind, input int value);
    int exp;
    checkOutput($sformatf("%s count", name), q_data.size(), NOUT);
    for (int k = 0; k < NOUT && k < q_data.size(); k++) begin
      exp = (kind == 0) ? value : 10 * (k / (W - 2) + 1);
      checkOutput($sformatf("%s data[%0d]", name, k), q_data[k], exp);
      checkOutput($sformatf("%s eof[%0d]", name, k), q_eof[k], (k == NOUT - 1) ? 1 : 0);
      if (k < beat_cyc.size())
        checkOutput($sformatf("%s latency[%0d]", name, k), q_cyc[k] - beat_cyc[k], 2);
    end
  endtask

  task automatic checkIdleOutputs(input string name);
    checkOutput({name, " out_valid"}, int'(out_valid), 0);
    checkOutput({name, " out_data"}, int'(out_data), 0);
    checkOutput({name, " out_eof"}, int'(out_eof), 0);
  endtask

  initial begin
    int imp_pos, imp_neg;
`ifdef SOBEL_CLAMP_EN
    imp_pos = 4095;
    imp_neg = 0;
`else
    imp_pos = 8190;
    imp_neg = -8190;
`endif
    vecs[0] = '{"const_m0",  0, 2'd0, 1'b0, 1'b0, 0, 0};
    vecs[1] = '{"hramp_m0",  1, 2'd0, 1'b0, 1'b0, 0, 80};
    vecs[2] = '{"hramp_m1",  1, 2'd1, 1'b0, 1'b0, 0, 0};
    vecs[3] = '{"vramp_m1",  2, 2'd1, 1'b0, 1'b0, 0, 80};
    vecs[4] = '{"vramp_m2",  2, 2'd2, 1'b0, 1'b0, 0, 80};
    vecs[5] = '{"vramp_m3",  2, 2'd3, 1'b0, 1'b0, 1, 0};
    vecs[6] = '{"hramp_gap", 1, 2'd0, 1'b1, 1'b1, 0, 80};

    rst = 1'b1; in_valid = 1'b0; in_pixel = '0; in_sof = 1'b0; mode = 2'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkIdleOutputs("reset");

    for (int i = 0; i < 7; i++) begin
      sendFrame(vecs[i].pattern, vecs[i].md, vecs[i].gapped, vecs[i].toggle);
      checkFrame(vecs[i].name, vecs[i].kind, vecs[i].value);
    end

    sendFrame(3, 2'd2, 1'b0, 1'b0);
    checkOutput("impulse_m2 count", q_data.size(), NOUT);
    if (q_data.size() == NOUT) begin
      checkOutput("impulse_m2 centre(2,2)", q_data[7], imp_pos);
      checkOutput("impulse_m2 centre(2,3)", q_data[8], 0);
      checkOutput("impulse_m2 centre(4,6)", q_data[23], 0);
    end
    sendFrame(3, 2'd0, 1'b0, 1'b0);
    checkOutput("impulse_m0 count", q_data.size(), NOUT);
    if (q_data.size() == NOUT) begin
      checkOutput("impulse_m0 centre(2,2)", q_data[7], imp_pos);
      checkOutput("impulse_m0 centre(2,4)", q_data[9], imp_neg);
    end

    // Mid-frame reset on beat (3,5) while two results are still in flight.
    clearQueues();
    for (int n = 0; n < 3 * W + 5; n++)
      applyStimulus(pix(1, n / W, n % W), (n == 0), 2'd0, 1'b1);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_pixel = pix(1, 3, 5); in_sof = 1'b0;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    checkIdleOutputs("midreset");
    clearQueues();
    for (int i = 0; i < 4; i++) applyStimulus('0, 1'b0, 2'd0, 1'b0);
    checkOutput("midreset flushed", q_data.size(), 0);
    sendFrame(1, 2'd0, 1'b0, 1'b0);
    checkFrame("after_reset", 0, 80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
